// File: rtl/lift_pkg.sv
// Shared definitions for the lift floor controller: FSM state codes,
// door-state codes, default timing constants and a floor-width helper.
package lift_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MOVE     = 2'd1;
    localparam logic [1:0] ST_DOOR_REQ = 2'd2;
    localparam logic [1:0] ST_DOOR_REL = 2'd3;

    localparam logic [1:0] PUERTA_ABIERTA  = 2'b00;
    localparam logic [1:0] PUERTA_ABRIENDO = 2'b01;
    localparam logic [1:0] PUERTA_CERRANDO = 2'b10;
    localparam logic [1:0] PUERTA_CERRADA  = 2'b11;

    // 3 s of travel per floor and 10 s of idling at 100 MHz
    localparam int unsigned TRAVEL_TIME_DEF  = 300_000_000;
    localparam int unsigned IDLE_TIMEOUT_DEF = 1_000_000_000;

    // floor index width, never narrower than one bit
    function automatic int ancho_piso(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/contador_viaje.sv
// 32-bit event counter with synchronous clear and enable. The terminal flag
// is high while the count sits at LIMITE-1; an enabled cycle at that value
// wraps the count back to zero.
module contador_viaje #(
    parameter int unsigned LIMITE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic fin
);

    logic [31:0] cuenta;

    // count enabled cycles; clear takes priority over counting
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cuenta <= '0;
        end else if (en) begin
            if (fin) cuenta <= '0;
            else     cuenta <= cuenta + 32'd1;
        end
    end

    assign fin = (cuenta == 32'(LIMITE - 1));

endmodule

// File: rtl/control_pisos.sv
// Lift floor-request controller: latches calls, sweeps the cabin up/down one
// floor per travel interval and handshakes with the door controller.
// Optional feature macro: RETORNO_BASE_EN (return to floor 0 after idling).
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | no door request, choose next target from requests
//   ST_MOVE     | cabin travelling, one floor per TRAVEL_TIME run cycles
//   ST_DOOR_REQ | iniciar_puerta high, waiting for puerta_done high
//   ST_DOOR_REL | iniciar_puerta low, waiting for puerta_done low
module control_pisos
    import lift_pkg::*;
#(
    parameter int          N_PISOS      = 4,
    parameter int unsigned TRAVEL_TIME  = TRAVEL_TIME_DEF,
    parameter int unsigned IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    localparam int         FW           = ancho_piso(N_PISOS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PISOS-1:0] btn_piso,
    input  logic               alarma,
    input  logic [1:0]         puerta_estado,
    input  logic               puerta_done,
    output logic               iniciar_puerta,
    output logic [FW-1:0]      piso_actual,
    output logic [N_PISOS-1:0] solicitudes,
    output logic               motor_subir,
    output logic               motor_bajar,
    output logic               en_movimiento
);

    localparam logic [FW-1:0] PISO_MAX = FW'(N_PISOS - 1);
    localparam logic [FW-1:0] UNO      = FW'(1);

    if (N_PISOS < 2 || TRAVEL_TIME < 1 || IDLE_TIMEOUT < 1) begin : g_param_err
        $error("control_pisos: N_PISOS >= 2, TRAVEL_TIME >= 1 and IDLE_TIMEOUT >= 1 required");
    end

    logic [1:0]         estado, estado_sig;
    logic               dir, dir_sig;
    logic [FW-1:0]      piso_sig;
    logic [N_PISOS-1:0] pulsado, borrar, sol_sig;
    logic               marcha, paso, fin_viaje, inyectar, corre_in;
    logic               hay_arriba, hay_abajo, en_puerta;

    // any request strictly beyond floor p in the given direction
    function automatic logic pendiente(input logic [N_PISOS-1:0] s,
                                       input logic [FW-1:0] p,
                                       input logic hacia_arriba);
        logic r;
        r = 1'b0;
        for (int i = 0; i < N_PISOS; i++) begin
            if (s[i] && (hacia_arriba ? (i > int'(p)) : (i < int'(p)))) r = 1'b1;
        end
        return r;
    endfunction

    assign hay_arriba = pendiente(solicitudes, piso_actual, 1'b1);
    assign hay_abajo  = pendiente(solicitudes, piso_actual, 1'b0);
    assign en_puerta  = (estado == ST_DOOR_REQ) || (estado == ST_DOOR_REL);
    assign corre_in   = (puerta_estado == PUERTA_CERRADA) && !alarma;

    // the counter advances exactly on cycles where a motor output is on
    assign marcha = motor_subir | motor_bajar;
    assign paso   = marcha & fin_viaje;

    contador_viaje #(.LIMITE(TRAVEL_TIME)) u_viaje (
        .clk (clk),
        .rst (rst),
        .clr (estado != ST_MOVE),
        .en  (marcha),
        .fin (fin_viaje)
    );

`ifdef RETORNO_BASE_EN
    logic ocioso, fin_ocio;
    assign ocioso = (estado == ST_IDLE) && (solicitudes == '0) && (piso_actual != '0);

    contador_viaje #(.LIMITE(IDLE_TIMEOUT)) u_ocio (
        .clk (clk),
        .rst (rst),
        .clr (!ocioso),
        .en  (ocioso),
        .fin (fin_ocio)
    );

    assign inyectar = ocioso & fin_ocio;
`else
    assign inyectar = 1'b0;
`endif

    // floor after a completed travel interval, held at the shaft ends
    always_comb begin
        piso_sig = piso_actual;
        if (paso) begin
            if (dir && piso_actual != PISO_MAX)  piso_sig = piso_actual + UNO;
            else if (!dir && piso_actual != '0)  piso_sig = piso_actual - UNO;
        end
    end

    // request latch: presses of the served floor are ignored at the door, clear wins
    always_comb begin
        pulsado = btn_piso;
        borrar  = '0;
        if (en_puerta) pulsado[piso_actual] = 1'b0;
        if (estado == ST_DOOR_REQ && puerta_done) borrar[piso_actual] = 1'b1;
        sol_sig = (solicitudes | pulsado | {{(N_PISOS-1){1'b0}}, inyectar}) & ~borrar;
    end

    // next state and sweep direction
    always_comb begin
        estado_sig = estado;
        dir_sig    = dir;
        case (estado)
            ST_IDLE: begin
                if (solicitudes[piso_actual]) begin
                    estado_sig = ST_DOOR_REQ;
                end else if (hay_arriba || hay_abajo) begin
                    estado_sig = ST_MOVE;
                    dir_sig    = dir ? hay_arriba : !hay_abajo;
                end
            end
            ST_MOVE: begin
                if (paso) begin
                    if (solicitudes[piso_sig])                   estado_sig = ST_DOOR_REQ;
                    else if (!pendiente(solicitudes, piso_sig, dir)) estado_sig = ST_IDLE;
                end
            end
            ST_DOOR_REQ: if (puerta_done)  estado_sig = ST_DOOR_REL;
            default:     if (!puerta_done) estado_sig = ST_IDLE;
        endcase
    end

    // state, request and registered output update
    always_ff @(posedge clk) begin
        if (rst) begin
            estado         <= ST_IDLE;
            dir            <= 1'b1;
            piso_actual    <= '0;
            solicitudes    <= '0;
            iniciar_puerta <= 1'b0;
            motor_subir    <= 1'b0;
            motor_bajar    <= 1'b0;
            en_movimiento  <= 1'b0;
        end else begin
            estado         <= estado_sig;
            dir            <= dir_sig;
            piso_actual    <= piso_sig;
            solicitudes    <= sol_sig;
            iniciar_puerta <= (estado_sig == ST_DOOR_REQ);
            motor_subir    <= (estado_sig == ST_MOVE) && dir_sig && corre_in;
            motor_bajar    <= (estado_sig == ST_MOVE) && !dir_sig && corre_in;
            en_movimiento  <= (estado_sig == ST_MOVE);
        end
    end

    // a step past either end of the shaft means the target decision is broken
    a_tope_arriba: assert property (@(posedge clk) disable iff (rst)
        !(paso && dir && piso_actual == PISO_MAX));
    a_tope_abajo: assert property (@(posedge clk) disable iff (rst)
        !(paso && !dir && piso_actual == '0));
    a_motores: assert property (@(posedge clk) disable iff (rst)
        !(motor_subir && motor_bajar));

endmodule

// File: tb/tb_control_pisos.sv
// Bench for control_pisos (N_PISOS=4, TRAVEL_TIME=10, IDLE_TIMEOUT=50).
// Honours RETORNO_BASE_EN when the same macro is given to the bench build.
module tb_control_pisos;
    import lift_pkg::*;

    localparam int NP      = 4;
    localparam int T       = 10;
    localparam int IDLE_TO = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] btn_piso = '0;
    logic          alarma = 1'b0;
    logic [1:0]    puerta_estado = PUERTA_CERRADA;
    logic          puerta_done = 1'b0;
    logic          iniciar_puerta;
    logic [1:0]    piso_actual;
    logic [NP-1:0] solicitudes;
    logic          motor_subir, motor_bajar, en_movimiento;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    control_pisos #(.N_PISOS(NP), .TRAVEL_TIME(T), .IDLE_TIMEOUT(IDLE_TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .btn_piso       (btn_piso),
        .alarma         (alarma),
        .puerta_estado  (puerta_estado),
        .puerta_done    (puerta_done),
        .iniciar_puerta (iniciar_puerta),
        .piso_actual    (piso_actual),
        .solicitudes    (solicitudes),
        .motor_subir    (motor_subir),
        .motor_bajar    (motor_bajar),
        .en_movimiento  (en_movimiento)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nombre, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nombre, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int F_REP = 0, F_VIAJE = 1, F_PIDE = 2, F_SUELTA = 3;

    int       m_piso = 0, m_dir = 1, m_fase = F_REP, m_resto = T, m_mot = 0;
    bit [NP-1:0] m_req = '0;
`ifdef RETORNO_BASE_EN
    int       m_ocio = 0;
`endif

    function automatic int mas_alla(input bit [NP-1:0] r, input int p, input int d);
        int c = 0;
        for (int i = 0; i < NP; i++)
            if (r[i] && ((d == 1 && i > p) || (d == 0 && i < p))) c++;
        return c;
    endfunction

    always @(posedge clk) begin : modelo
        bit [NP-1:0] nr;
        int np, nd, nf, nres;
`ifdef RETORNO_BASE_EN
        int noc;
`endif
        if (rst) begin
            m_piso <= 0; m_dir <= 1; m_fase <= F_REP; m_resto <= T; m_mot <= 0; m_req <= '0;
`ifdef RETORNO_BASE_EN
            m_ocio <= 0;
`endif
        end else begin
            nr = m_req; np = m_piso; nd = m_dir; nf = m_fase; nres = m_resto;
            for (int i = 0; i < NP; i++)
                if (btn_piso[i] && !((m_fase == F_PIDE || m_fase == F_SUELTA) && i == m_piso))
                    nr[i] = 1'b1;
            case (m_fase)
                F_REP: begin
                    if (m_req[m_piso]) nf = F_PIDE;
                    else if (m_req != '0) begin
                        if (mas_alla(m_req, m_piso, m_dir) == 0) nd = 1 - m_dir;
                        nf = F_VIAJE; nres = T;
                    end
                end
                F_VIAJE: begin
                    if (m_mot != 0) begin
                        nres = m_resto - 1;
                        if (nres == 0) begin
                            np = (m_dir == 1) ? m_piso + 1 : m_piso - 1;
                            nres = T;
                            if (m_req[np]) nf = F_PIDE;
                            else if (mas_alla(m_req, np, m_dir) == 0) nf = F_REP;
                        end
                    end
                end
                F_PIDE:  if (puerta_done) begin nr[m_piso] = 1'b0; nf = F_SUELTA; end
                default: if (!puerta_done) nf = F_REP;
            endcase
`ifdef RETORNO_BASE_EN
            noc = 0;
            if (m_fase == F_REP && m_req == '0 && m_piso != 0) begin
                noc = m_ocio + 1;
                if (noc == IDLE_TO) begin nr[0] = 1'b1; noc = 0; end
            end
            m_ocio <= noc;
`endif
            m_piso <= np; m_dir <= nd; m_fase <= nf; m_resto <= nres; m_req <= nr;
            m_mot  <= (nf == F_VIAJE && puerta_estado == PUERTA_CERRADA && !alarma) ?
                      ((nd == 1) ? 1 : -1) : 0;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_piso",        int'(piso_actual),    m_piso);
            chk("m_solicitudes", int'(solicitudes),    int'(m_req));
            chk("m_subir",       int'(motor_subir),    (m_mot == 1) ? 1 : 0);
            chk("m_bajar",       int'(motor_bajar),    (m_mot == -1) ? 1 : 0);
            chk("m_iniciar",     int'(iniciar_puerta), (m_fase == F_PIDE) ? 1 : 0);
            chk("m_movimiento",  int'(en_movimiento),  (m_fase == F_VIAJE) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulsar(input logic [NP-1:0] m);
        btn_piso = m;
        @(negedge clk);
        btn_piso = '0;
    endtask

    task automatic esperar_piso(input int f, input int limite, output int n);
        n = 0;
        while (int'(piso_actual) != f && n < limite) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic atender(input string nombre, input int piso_esp);
        int n = 0;
        while (!iniciar_puerta && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({nombre, "_inicio"}, int'(iniciar_puerta), 1);
        chk({nombre, "_piso"},   int'(piso_actual), piso_esp);
        puerta_estado = PUERTA_ABRIENDO;
        tick(1);
        puerta_estado = PUERTA_ABIERTA;
        puerta_done = 1'b1;
        @(negedge clk);
        chk({nombre, "_ini_cae"}, int'(iniciar_puerta), 0);
        chk({nombre, "_led"},     int'(solicitudes[piso_esp]), 0);
        puerta_estado = PUERTA_CERRANDO;
        tick(2);
        puerta_done = 1'b0;
        puerta_estado = PUERTA_CERRADA;
        tick(1);
    endtask

    task automatic chk_ceros(input string nombre);
        chk({nombre, "_piso"}, int'(piso_actual), 0);
        chk({nombre, "_sol"},  int'(solicitudes), 0);
        chk({nombre, "_mot"},  int'({motor_subir, motor_bajar}), 0);
        chk({nombre, "_ini"},  int'(iniciar_puerta), 0);
        chk({nombre, "_mov"},  int'(en_movimiento), 0);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int n, m;
        tick(2);
        chk_en = 1'b1;
        chk_ceros("reset");
        rst = 1'b0;
        tick(1);

        // call to the top floor: step every 10 running cycles
        pulsar(4'b1000);
        tick(1);
        chk("mueve_subir", int'(motor_subir), 1);
        chk("mueve_mov",   int'(en_movimiento), 1);
        esperar_piso(1, 100, n);
        chk("t_piso1", n + 2, 12);
        esperar_piso(2, 100, n);
        chk("t_piso2", n, 10);
        esperar_piso(3, 100, n);
        chk("t_piso3", n, 10);
        chk("llega3_ini", int'(iniciar_puerta), 1);
        atender("d3", 3);

        // reposition to floor 1, then calls above and below together
        rst = 1'b1;
        tick(2);
        chk_ceros("rst_idle");
        rst = 1'b0;
        pulsar(4'b0010);
        atender("d1", 1);
        pulsar(4'b1001);
        atender("d3b", 3);
        tick(1);
        chk("reverso_bajar", int'(motor_bajar), 1);
        chk("reverso_subir", int'(motor_subir), 0);
        tick(5);
        puerta_estado = PUERTA_CERRANDO;
        tick(4);
        puerta_estado = PUERTA_CERRADA;
        atender("d0", 0);

        // alarm for 25 cycles during travel delays the step by 25 cycles
        pulsar(4'b0100);
        esperar_piso(1, 100, n);
        chk("t_alarma_p1", n + 1, 12);
        m = 0;
        repeat (4) begin @(negedge clk); m++; end
        alarma = 1'b1;
        repeat (12) begin @(negedge clk); m++; end
        chk("alarma_motor", int'({motor_subir, motor_bajar}), 0);
        repeat (13) begin @(negedge clk); m++; end
        alarma = 1'b0;
        esperar_piso(2, 100, n);
        chk("t_alarma_p2", m + n, 35);
        atender("d2", 2);

        // call of the current floor, repeated during the door request
        pulsar(4'b0100);
        tick(1);
        chk("aqui_ini", int'(iniciar_puerta), 1);
        chk("aqui_mot", int'({motor_subir, motor_bajar}), 0);
        pulsar(4'b0100);
        atender("d2b", 2);
        chk("aqui_sol", int'(solicitudes), 0);

`ifdef RETORNO_BASE_EN
        atender("base", 0);
`else
        tick(80);
        chk("ocio_piso", int'(piso_actual), 2);
        chk("ocio_sol",  int'(solicitudes), 0);
`endif

        // reset in the middle of a trip
        pulsar(4'b1000);
        tick(5);
        rst = 1'b1;
        tick(2);
        chk_ceros("rst_viaje");
        rst = 1'b0;
        pulsar(4'b0010);
        esperar_piso(1, 100, n);
        chk("t_tras_rst", n + 1, 12);
        atender("dfin", 1);
        tick(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
